// File: rtl/alu_bist_ctrl_if.sv
// ALU-side bus of the BIST controller: operands and mode out, result in.
// The controller takes the master view, the ALU takes the slave view.
interface alu_bist_ctrl_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] a_o;
    logic [SIZE-1:0] b_o;
    logic [2:0]      mode_o;
    logic [SIZE-1:0] s_i;
    logic            c_i;

    modport master (
        output a_o, b_o, mode_o,
        input  s_i, c_i
    );

    modport slave (
        input  a_o, b_o, mode_o,
        output s_i, c_i
    );
endinterface

// File: rtl/alu_bist_ctrl.sv
// LFSR-driven BIST for the combinational ALU with MISR signature compaction.
// Optional macro ALU_BIST_ABORT_EN adds abort_i to cancel a run in progress.
module alu_bist_ctrl #(
    parameter int                SIZE        = 8,
    parameter int                NB_PATTERNS = 64,
    parameter logic [2*SIZE-1:0] LFSR_POLY   = 16'hB400,
    parameter logic [2*SIZE-1:0] SEED        = 16'hACE1,
    parameter logic [SIZE:0]     GOLDEN      = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
`ifdef ALU_BIST_ABORT_EN
    input  logic                 abort_i,
`endif
    alu_bist_ctrl_if.master      alu,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [SIZE:0]        signature_o
);
    localparam int CW  = $clog2(NB_PATTERNS + 1);
    localparam int CWX = (CW < 3) ? 3 : CW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [2*SIZE-1:0] lfsr;
    logic [CW-1:0]     count;
    logic [SIZE:0]     sig;

    logic [CWX-1:0]    cnt_x;
    logic              run;
    logic [2:0]        mode;
    logic              c_m;
    logic [SIZE-1:0]   s_m;
    logic [SIZE:0]     sig_nxt;
    logic [2*SIZE-1:0] lfsr_nxt;
    logic              last;

    assign cnt_x = CWX'(count);
    assign run   = (state == RUN);
    assign mode  = run ? cnt_x[2:0] : 3'b111;

    assign alu.a_o    = run ? lfsr[2*SIZE-1:SIZE] : '0;
    assign alu.b_o    = run ? lfsr[SIZE-1:0] : '0;
    assign alu.mode_o = mode;

    // Carry is only meaningful for add/sub; compare only defines bit 0
    always_comb begin
        c_m = (mode[2:1] == 2'b00) ? alu.c_i : 1'b0;
        s_m = alu.s_i;
        if (mode == 3'b110) begin
            s_m[SIZE-1:1] = '0;
        end
    end

    assign sig_nxt  = {sig[SIZE-1:0], sig[SIZE]} ^ {c_m, s_m};
    assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
    assign last     = (count == CW'(NB_PATTERNS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            lfsr  <= SEED;
            count <= '0;
            sig   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state <= RUN;
                        lfsr  <= SEED;
                        count <= '0;
                        sig   <= '0;
                    end
                end
                RUN: begin
`ifdef ALU_BIST_ABORT_EN
                    if (abort_i) begin
                        state <= IDLE;
                        sig   <= '0;
                    end else begin
                        sig   <= sig_nxt;
                        lfsr  <= lfsr_nxt;
                        count <= count + 1'b1;
                        if (last) state <= DONE;
                    end
`else
                    sig   <= sig_nxt;
                    lfsr  <= lfsr_nxt;
                    count <= count + 1'b1;
                    if (last) state <= DONE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = run;
    assign done_o      = (state == DONE);
    assign pass_o      = done_o && (sig == GOLDEN);
    assign signature_o = sig;
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: good, mis-golden and faulty-ALU DUTs.
// Expected patterns go through a scoreboard queue; signatures come from a model.
module tb_alu_bist_ctrl;
    localparam int NB = 8;
    localparam logic [15:0] SEED_V = 16'hACE1;
    localparam logic [15:0] POLY_V = 16'hB400;

    function automatic logic [15:0] lfsr_f(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? POLY_V : 16'h0000);
    endfunction

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] md, input logic fault);
        logic [8:0] r;
        case (md)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {1'b0, a} - {1'b0, b};
            3'd2: r = {^a, a ^ b};
            3'd3: r = {^b, a | b};
            3'd4: r = {1'b1, a & b};
            3'd5: r = {a[7], ~a};
            3'd6: r = {1'b1, a[7:1], (a < b)};
            default: r = {a[0], b};
        endcase
        if (fault && md == 3'd2) r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic [8:0] golden_f(input logic fault);
        logic [15:0] l;
        logic [8:0]  sg;
        logic [8:0]  r;
        logic [7:0]  sm;
        logic        cm;
        logic [2:0]  md;
        l  = SEED_V;
        sg = '0;
        for (int k = 0; k < NB; k++) begin
            md = k[2:0];
            r  = alu_f(l[15:8], l[7:0], md, fault);
            cm = (md == 3'd0 || md == 3'd1) ? r[8] : 1'b0;
            sm = r[7:0];
            if (md == 3'd6) sm[7:1] = '0;
            sg = {sg[7:0], sg[8]} ^ {cm, sm};
            l  = lfsr_f(l);
        end
        return sg;
    endfunction

    localparam logic [8:0] GOLD   = golden_f(1'b0);
    localparam logic [8:0] GOLD_F = golden_f(1'b1);

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic [2:0] busy, done, pass;
    logic [8:0] sig [3];

    always #5 clk = ~clk;

    alu_bist_ctrl_if #(.SIZE(8)) bus0 ();
    alu_bist_ctrl_if #(.SIZE(8)) bus1 ();
    alu_bist_ctrl_if #(.SIZE(8)) bus2 ();

    always_comb {bus0.c_i, bus0.s_i} = alu_f(bus0.a_o, bus0.b_o, bus0.mode_o, 1'b0);
    always_comb {bus1.c_i, bus1.s_i} = alu_f(bus1.a_o, bus1.b_o, bus1.mode_o, 1'b0);
    always_comb {bus2.c_i, bus2.s_i} = alu_f(bus2.a_o, bus2.b_o, bus2.mode_o, 1'b1);

    alu_bist_ctrl #(.SIZE(8), .NB_PATTERNS(NB), .GOLDEN(GOLD)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
`ifdef ALU_BIST_ABORT_EN
        .abort_i(abort),
`endif
        .alu(bus0), .busy_o(busy[0]), .done_o(done[0]),
        .pass_o(pass[0]), .signature_o(sig[0])
    );

    alu_bist_ctrl #(.SIZE(8), .NB_PATTERNS(NB), .GOLDEN(GOLD ^ 9'd1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
`ifdef ALU_BIST_ABORT_EN
        .abort_i(abort),
`endif
        .alu(bus1), .busy_o(busy[1]), .done_o(done[1]),
        .pass_o(pass[1]), .signature_o(sig[1])
    );

    alu_bist_ctrl #(.SIZE(8), .NB_PATTERNS(NB), .GOLDEN(GOLD)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
`ifdef ALU_BIST_ABORT_EN
        .abort_i(abort),
`endif
        .alu(bus2), .busy_o(busy[2]), .done_o(done[2]),
        .pass_o(pass[2]), .signature_o(sig[2])
    );

    int checks = 0;
    int passed = 0;
    logic [18:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy[0]), 32'd0);
        chk({tag, "_done"}, 32'(done[0]), 32'd0);
        chk({tag, "_pass"}, 32'(pass[0]), 32'd0);
        chk({tag, "_sig"}, 32'(sig[0]), 32'd0);
        chk({tag, "_ab"}, {16'h0, bus0.a_o, bus0.b_o}, 32'd0);
        chk({tag, "_mode"}, 32'(bus0.mode_o), 32'd7);
    endtask

    task automatic run_check(input bit hold);
        logic [15:0] l;
        logic [18:0] e;
        l = SEED_V;
        for (int k = 0; k < NB; k++) begin
            sb.push_back({l, 3'(k)});
            l = lfsr_f(l);
        end
        start = 1'b1;
        @(negedge clk);
        chk("busy_rise", 32'(busy[0]), 32'd1);
        chk("done_drop", 32'(done[0]), 32'd0);
        chk("pass_drop", 32'(pass[0]), 32'd0);
        chk("sig_clear", 32'(sig[0]), 32'd0);
        if (!hold) start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            if (k == NB - 1) start = 1'b0;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pattern", {13'h0, bus0.a_o, bus0.b_o, bus0.mode_o}, 32'(e));
            end
            chk("busy_run", 32'(busy[0]), 32'd1);
            chk("done_early", 32'(done[0]), 32'd0);
        end
        @(negedge clk);
        chk("done_rise", 32'(done[0]), 32'd1);
        chk("busy_fall", 32'(busy[0]), 32'd0);
        chk("sig_good", 32'(sig[0]), 32'(GOLD));
        chk("pass_good", 32'(pass[0]), 32'd1);
        chk("pass_badgold", 32'(pass[1]), 32'd0);
        chk("sig_fault", 32'(sig[2]), 32'(GOLD_F));
        chk("pass_fault", 32'(pass[2]), 32'd0);
        repeat (2) @(negedge clk);
        chk("done_hold", 32'(done[0]), 32'd1);
        chk("one_run", 32'(busy[0]), 32'd0);
        chk("sig_hold", 32'(sig[0]), 32'(GOLD));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk_idle("reset");
        chk("gold_differs", 32'(GOLD ^ GOLD_F) != 0 ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        start = 1'b1;
        @(negedge clk);
        chk("pat0", {13'h0, bus0.a_o, bus0.b_o, bus0.mode_o}, {13'h0, 8'hAC, 8'hE1, 3'd0});
        start = 1'b0;
        @(negedge clk);
        chk("pat1", {13'h0, bus0.a_o, bus0.b_o, bus0.mode_o}, {13'h0, 8'hE2, 8'h70, 3'd1});
        rst_n = 1'b0;
        #1;
        chk_idle("rst_early");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_check(1'b1);
        run_check(1'b0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_mode3", 32'(bus0.mode_o), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check(1'b0);

`ifdef ALU_BIST_ABORT_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        @(negedge clk);
        chk("abort_nodone", 32'(done[0]), 32'd0);
        run_check(1'b0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

Synthesizable built-in self-test controller for the combinational ALU. It drives the ALU's operand and mode inputs with pseudo-random patterns and compacts the ALU's results into a signature. At the end of a run it reports pass/fail against a golden value. It sits between the ALU and the test-control logic, on the side of the ALU interface opposite the result checkers.

## Interface
Parameters:
- SIZE, 8, ALU operand width
- NB_PATTERNS, 64, patterns per run (≥1)
- LFSR_POLY, 16'hB400, Galois feedback mask, width 2*SIZE
- SEED, 16'hACE1, LFSR reset/start value, width 2*SIZE, non-zero
- GOLDEN, '0, expected final signature, width SIZE+1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- start_i  in  1  run request (level, sampled in IDLE/DONE)
- a_o  out  SIZE  ALU operand A
- b_o  out  SIZE  ALU operand B
- mode_o  out  3  ALU mode
- s_i  in  SIZE  ALU result
- c_i  in  1  ALU carry
- busy_o  out  1  run in progress
- done_o  out  1  run finished, result valid
- pass_o  out  1  signature == GOLDEN (valid while done_o)
- signature_o  out  SIZE+1  current MISR value

## Operation
- FSM states:
  - IDLE: wait for start_i=1, then go to RUN.
  - RUN: runs NB_PATTERNS cycles, then goes to DONE.
  - DONE: holds the result. start_i=1 goes to RUN (restart).
- Entering RUN:
  - lfsr←SEED, count←0, signature←0.
  - {a_o,b_o} = lfsr (a_o = upper SIZE bits).
  - mode_o = count[2:0], so all 8 modes are exercised every 8 patterns.
- Each RUN cycle:
  - The ALU responds combinationally to a_o/b_o/mode_o in the same cycle.
  - Masking before absorption:
    - c_i is forced to 0 unless mode_o ∈ {000,001}.
    - For mode 110, s_i[SIZE-1:1] is forced to 0.
  - Absorb: signature ← rotl1(signature) XOR {c_masked, s_masked}.
  - Advance: lfsr ← (lfsr>>1) XOR (lfsr[0] ? LFSR_POLY : 0), and count ← count+1.
- Leaving RUN: after the absorb with count = NB_PATTERNS-1.
- Counter width: $clog2(NB_PATTERNS+1).
- Outputs in IDLE and DONE: a_o = b_o = 0, mode_o = 3'b111.
- start_i while in RUN is ignored.

## Timing
- Reset values: a_o=0, b_o=0, mode_o=3'b111, busy_o=0, done_o=0, pass_o=0, signature_o=0. The FSM resets to IDLE.
- start_i high at edge n:
  - busy_o=1 and the first pattern appear after edge n.
  - The k-th pattern (k from 0) is driven during cycle n+1+k.
- After edge n+NB_PATTERNS:
  - busy_o=0 and done_o=1.
  - signature_o holds the final value and pass_o is valid.
  - All three hold until restart or reset.
- Run latency: NB_PATTERNS+1 cycles from start to done_o.
- Restart from DONE: done_o and pass_o drop in the same cycle busy_o rises.
- Asynchronous reset mid-run: immediate return to reset values. No partial result is retained.

## Configuration
- Macro: ALU_BIST_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in RUN goes to IDLE at the next edge: busy_o=0, done_o=0, pass_o=0, signature reset to 0.
  - abort_i is ignored in other states.
- Undefined:
  - No abort_i port.
  - A run always completes.

## Test plan
- Reset: assert rst_ni=0 mid-cycle -> all outputs take their reset values immediately, without waiting for a clock edge.
- Sequence (NB_PATTERNS=8, default SEED, start pulse):
  - a_o/b_o = 0xAC/0xE1 with mode 000, then 0xE2/0x70 with mode 001.
  - mode_o steps 0..7.
  - done_o rises exactly 9 cycles after start.
- Golden match: bench ALU model plus the bench-computed signature passed as GOLDEN -> pass_o=1. Same with GOLDEN XOR 1 -> pass_o=0.
- Fault detection: ALU with a stuck s_o[0]=0 in mode 010 -> final signature ≠ golden, pass_o=0.
- Restart and ignore:
  - start_i held high through the run -> exactly one run.
  - start_i high in DONE -> new run, done_o=0 in the same cycle busy_o=1.
  - The same signature is produced again.
- Reset/abort mid-run:
  - rst_ni low at pattern 3 -> IDLE, then a fresh start gives the full correct result.
  - With ALU_BIST_ABORT_EN, abort_i at pattern 3 -> busy_o=0 next cycle, done_o stays 0.
